pps_holdover_ctrl: RTL and testbench

Supervises the single-cycle 1PPS pulse produced by the PPS receiver and decides what the fabric sees as "the second". Qualifies incoming pulses against the nominal period and locks after consecutive good intervals. Free-runs a synthetic PPS (holdover) when the reference disappears and falls back to search after a bounded holdover. Sits in the core clock domain between the PPS receiver output and all PPS consumers.

---
 rtl/pps_holdover_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pps_holdover_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pps_holdover_ctrl.sv
// pps_holdover_ctrl: qualifies the receiver 1PPS, locks, and free-runs on loss.
// Optional macro PPS_HOLDOVER_CTRL_IRQ_EN enables the irq_state change pulse.
module pps_holdover_ctrl #(
    parameter int unsigned C_CLOCK_FREQUENCY = 125000000,
    parameter int unsigned C_TOLERANCE       = 1000,
    parameter int unsigned C_LOCK_COUNT      = 3,
    parameter int unsigned C_HOLDOVER_MAX    = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pps_in,
    output logic        pps_out,
    output logic        pps_valid,
    output logic [1:0]  state,
    output logic [31:0] phase_err,
    output logic        irq_state
);

    typedef enum logic [1:0] {
        ST_SEARCH   = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_HOLDOVER = 2'd2
    } st_t;

    localparam logic [31:0] N   = 32'(C_CLOCK_FREQUENCY);
    localparam logic [31:0] TOL = 32'(C_TOLERANCE);

    // Earliest loc+1 at which a pulse is accepted while locked.
    localparam logic [31:0] LK_LO = N - TOL;
    // Last loc value still waiting for a real pulse while locked.
    localparam logic [31:0] LK_TO = N + TOL - 32'd1;
    // Holdover: window around the synthetic edge that re-locks.
    localparam logic [31:0] HO_LO = N - 32'd1 - TOL;
    localparam logic [31:0] HO_EG = N - 32'd1;

    // Search acceptance window on the pulse spacing D.
    localparam logic [32:0] D_LO = {1'b0, N - TOL};
    localparam logic [32:0] D_HI = {1'b0, N} + {1'b0, TOL};

    localparam logic [3:0]  LK_CNT = 4'(C_LOCK_COUNT);
    localparam logic [16:0] HO_MAX = 17'(C_HOLDOVER_MAX);

    st_t         state_q;
    st_t         state_d;
    logic [31:0] loc_q;
    logic [31:0] loc_d;
    logic [31:0] iv_q;
    logic [31:0] iv_d;
    logic        first_q;
    logic        first_d;
    logic [3:0]  good_q;
    logic [3:0]  good_d;
    logic [15:0] ho_q;
    logic [15:0] ho_d;

    logic        edge_ev;
    logic        ph_ld;
    logic [31:0] ph_val;

    logic        pps_d;
    logic        valid_d;
    logic [31:0] phase_d;

    logic [32:0] d_span;
    logic        d_good;
    logic [3:0]  good_inc;
    logic [16:0] ho_inc;
    logic [31:0] loc_inc;

    assign d_span   = {1'b0, iv_q} + 33'd1;
    assign d_good   = (d_span >= D_LO) && (d_span <= D_HI);
    assign good_inc = good_q + 4'd1;
    assign ho_inc   = {1'b0, ho_q} + 17'd1;
    assign loc_inc  = loc_q + 32'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter update decisions.
    always_comb begin
        state_d = state_q;
        edge_ev = 1'b0;
        ph_ld   = 1'b0;
        ph_val  = 32'd0;
        loc_d   = loc_inc;
        iv_d    = (iv_q == 32'hFFFF_FFFF) ? iv_q : iv_q + 32'd1;
        first_d = first_q;
        good_d  = good_q;
        ho_d    = ho_q;
        unique case (state_q)
            ST_SEARCH: begin
                loc_d = 32'd0;
                if (pps_in) begin
                    iv_d    = 32'd0;
                    first_d = 1'b1;
                    if (first_q) begin
                        if (!d_good) begin
                            good_d = 4'd0;
                        end else if (good_inc >= LK_CNT) begin
                            // Locking pulse defines the first second.
                            state_d = ST_LOCKED;
                            edge_ev = 1'b1;
                            good_d  = 4'd0;
                            loc_d   = 32'd0;
                            ph_ld   = 1'b1;
                            ph_val  = d_span[31:0] - N;
                        end else begin
                            good_d = good_inc;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (pps_in && (loc_inc >= LK_LO)) begin
                    edge_ev = 1'b1;
                    loc_d   = 32'd0;
                    ph_ld   = 1'b1;
                    ph_val  = loc_inc - N;
                end else if (loc_q == LK_TO) begin
                    // Late edge; loc restarts at TOL so later
                    // synthetic edges stay N after the last real one.
                    edge_ev = 1'b1;
                    loc_d   = TOL;
                    ho_d    = 16'd1;
                    if (HO_MAX <= 17'd1) begin
                        state_d = ST_SEARCH;
                        good_d  = 4'd0;
                        first_d = 1'b0;
                    end else begin
                        state_d = ST_HOLDOVER;
                    end
                end
            end
            ST_HOLDOVER: begin
                if (pps_in && (loc_q >= HO_LO)) begin
                    state_d = ST_LOCKED;
                    edge_ev = 1'b1;
                    loc_d   = 32'd0;
                    ph_ld   = 1'b1;
                    ph_val  = loc_inc - N;
                end else if (pps_in && (loc_q < TOL)) begin
                    // Pulse just after a synthetic edge: the second
                    // was already emitted, only realign.
                    state_d = ST_LOCKED;
                    loc_d   = 32'd0;
                    ph_ld   = 1'b1;
                    ph_val  = loc_inc;
                end else if (loc_q == HO_EG) begin
                    edge_ev = 1'b1;
                    loc_d   = 32'd0;
                    ho_d    = ho_inc[15:0];
                    if (ho_inc >= HO_MAX) begin
                        state_d = ST_SEARCH;
                        good_d  = 4'd0;
                        first_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = 4'd0;
                first_d = 1'b0;
                loc_d   = 32'd0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        pps_d   = edge_ev;
        valid_d = (state_d == ST_LOCKED) || (state_d == ST_HOLDOVER);
        phase_d = ph_ld ? ph_val : phase_err;
    end

    // Interval, phase and qualification counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loc_q   <= 32'd0;
            iv_q    <= 32'd0;
            first_q <= 1'b0;
            good_q  <= 4'd0;
            ho_q    <= 16'd0;
        end else begin
            loc_q   <= loc_d;
            iv_q    <= iv_d;
            first_q <= first_d;
            good_q  <= good_d;
            ho_q    <= ho_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pps_out   <= 1'b0;
            pps_valid <= 1'b0;
            phase_err <= 32'd0;
        end else begin
            pps_out   <= pps_d;
            pps_valid <= valid_d;
            phase_err <= phase_d;
        end
    end

    assign state = state_q;

`ifdef PPS_HOLDOVER_CTRL_IRQ_EN
    logic irq_d;

    assign irq_d = (state_d != state_q);

    // One-cycle pulse on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_state <= 1'b0;
        end else begin
            irq_state <= irq_d;
        end
    end
`else
    assign irq_state = 1'b0;
`endif

endmodule

// File: tb/tb_pps_holdover_ctrl.sv
// tb_pps_holdover_ctrl: directed scenarios for pps_holdover_ctrl.
// N=1000, TOL=10, LOCK_COUNT=3, HOLDOVER_MAX=4.
module tb_pps_holdover_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        pps_in;
    logic        pps_out;
    logic        pps_valid;
    logic [1:0]  state;
    logic [31:0] phase_err;
    logic        irq_state;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int pulses[$];
    int seen[$];

`ifdef PPS_HOLDOVER_CTRL_IRQ_EN
    localparam logic [31:0] IRQ_HI = 32'd1;
`else
    localparam logic [31:0] IRQ_HI = 32'd0;
`endif

    always #5 clk = ~clk;

    pps_holdover_ctrl #(
        .C_CLOCK_FREQUENCY(1000),
        .C_TOLERANCE(10),
        .C_LOCK_COUNT(3),
        .C_HOLDOVER_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pps_in(pps_in),
        .pps_out(pps_out),
        .pps_valid(pps_valid),
        .state(state),
        .phase_err(phase_err),
        .irq_state(irq_state)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        pps_in = 1'b0;
        foreach (pulses[i]) if (pulses[i] == cyc) pps_in = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (pps_out === 1'b1) seen.push_back(cyc);
    endtask

    task automatic run_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic check_seen(input string tag, input int exp[$]);
        int got;
        check({tag, "_cnt"}, seen.size(), exp.size());
        foreach (exp[i]) begin
            got = (i < seen.size()) ? seen[i] : -1;
            check($sformatf("%s_%0d", tag, i), got, exp[i]);
        end
    endtask

    task automatic reset_dut(input string tag);
        rst    = 1'b1;
        pps_in = 1'b0;
        pulses.delete();
        seen.delete();
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_rst_flags"},
              32'({pps_out, pps_valid, irq_state, state}), 32'd0);
        check({tag, "_rst_phase"}, phase_err, 32'd0);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Lock, then holdover and loss.
        reset_dut("lock");
        pulses = '{100, 1100, 2100, 3100};
        run_until(3100);
        check("lock_pre_state", state, 32'd0);
        check("lock_pre_pps", seen.size(), 32'd0);
        run_until(3101);
        check("lock_pps", pps_out, 32'd1);
        check("lock_state", state, 32'd1);
        check("lock_valid", pps_valid, 32'd1);
        check("lock_irq", irq_state, IRQ_HI);
        run_until(3102);
        check("lock_irq_clr", irq_state, 32'd0);
        run_until(4110);
        check("ho_pre_state", state, 32'd1);
        run_until(4111);
        check("ho_state", state, 32'd2);
        check("ho_pps", pps_out, 32'd1);
        check("ho_irq", irq_state, IRQ_HI);
        run_until(7100);
        check("loss_pre_valid", pps_valid, 32'd1);
        run_until(7101);
        check("loss_pps", pps_out, 32'd1);
        check("loss_state", state, 32'd0);
        check("loss_valid", pps_valid, 32'd0);
        run_until(8200);
        check_seen("ho_seen", '{3101, 4111, 5101, 6101, 7101});

        // Reacquire from holdover just after a synthetic edge.
        reset_dut("reacq");
        pulses = '{100, 1100, 2100, 3100, 5105, 6105};
        run_until(5101);
        check("reacq_syn_pps", pps_out, 32'd1);
        check("reacq_syn_state", state, 32'd2);
        run_until(5106);
        check("reacq_pps", pps_out, 32'd0);
        check("reacq_state", state, 32'd1);
        check("reacq_phase", phase_err, 32'd5);
        run_until(6106);
        check("reacq_next_pps", pps_out, 32'd1);
        check("reacq_next_phase", phase_err, 32'd0);
        check_seen("reacq_seen", '{3101, 4111, 5101, 6106});

        // Glitch rejection and acceptance window edges while locked.
        reset_dut("glitch");
        pulses = '{100, 1100, 2100, 3100, 3600, 4100,
                   5105, 6100, 7090, 8079, 8100};
        run_until(3601);
        check("glitch_pps", pps_out, 32'd0);
        check("glitch_state", state, 32'd1);
        run_until(4101);
        check("glitch_next_pps", pps_out, 32'd1);
        check("glitch_next_phase", phase_err, 32'd0);
        run_until(5106);
        check("late5_phase", phase_err, 32'd5);
        run_until(6101);
        check("early5_phase", phase_err, 32'hFFFF_FFFB);
        run_until(7091);
        check("early10_phase", phase_err, 32'hFFFF_FFF6);
        run_until(8080);
        check("early11_state", state, 32'd1);
        run_until(8101);
        check("late10_phase", phase_err, 32'd10);
        check("late10_state", state, 32'd1);
        check_seen("glitch_seen", '{3101, 4101, 5106, 6101, 7091, 8101});

        // A bad interval clears the good count.
        reset_dut("search");
        pulses = '{0, 1000, 2020, 3020, 4020, 5020};
        run_until(5020);
        check("search_pre_state", state, 32'd0);
        check("search_pre_pps", seen.size(), 32'd0);
        run_until(5021);
        check("search_state", state, 32'd1);
        check("search_pps", pps_out, 32'd1);

        // Asynchronous reset in the middle of holdover.
        reset_dut("arst");
        pulses = '{100, 1100, 2100, 3100};
        run_until(5500);
        check("arst_pre_state", state, 32'd2);
        check("arst_pre_valid", pps_valid, 32'd1);
        seen.delete();
        rst = 1'b1;
        #1;
        check("arst_flags",
              32'({pps_out, pps_valid, irq_state, state}), 32'd0);
        check("arst_phase", phase_err, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        run_until(6200);
        check("arst_no_pps", seen.size(), 32'd0);
        check("arst_state", state, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
